// File: rtl/relu_pool_streamer.sv
// relu_pool_streamer
// Takes the 1-D conv engine's result vector and turns it into a byte stream for the next layer.
// The vector is captured when the engine's done pulse arrives. Each output is the max over POOL
// adjacent entries, then ReLU, then an arithmetic right shift by SHIFT, then unsigned saturation
// to OUT_W bits. The N_IN/POOL outputs leave over a valid/ready handshake, in index order.
//
// Ports
//   clk          in   single clock, all logic on posedge
//   rst          in   synchronous reset, active low
//   in_valid     in   one-cycle pulse: conv_result holds a new frame
//   conv_result  in   N_IN signed IN_W-bit results, sampled only when the frame is accepted
//   out_valid    out  out_data/out_idx/out_last are valid
//   out_ready    in   consumer accepts on a posedge where out_valid && out_ready
//   out_data     out  pooled, rectified, shifted, saturated value
//   out_idx      out  index of the current output, 0..N_IN/POOL-1
//   out_last     out  high with the final output of a frame
//   busy         out  high from capture until the last handshake completes
//   done         out  one-cycle pulse the cycle after the last handshake
//   overrun      out  one-cycle pulse when a frame arrives while busy (that frame is dropped)
module relu_pool_streamer #(
  parameter int N_IN  = 30,
  parameter int IN_W  = 18,
  parameter int POOL  = 2,
  parameter int SHIFT = 2,
  parameter int OUT_W = 8,
  localparam int N_OUT = N_IN / POOL,
  localparam int K_W   = (N_OUT > 1) ? $clog2(N_OUT) : 1
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   in_valid,
  input  logic signed [IN_W-1:0] conv_result [0:N_IN-1],
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [OUT_W-1:0]       out_data,
  output logic [K_W-1:0]         out_idx,
  output logic                   out_last,
  output logic                   busy,
  output logic                   done,
  output logic                   overrun
);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_LOAD   = 2'd1,
    ST_STREAM = 2'd2
  } state_t;

  localparam logic [K_W-1:0]         LAST_IDX = K_W'(N_OUT - 1);
  localparam logic [K_W-1:0]         ONE_IDX  = K_W'(1);
  localparam logic signed [IN_W-1:0] ZERO_VAL = {IN_W{1'b0}};
  localparam logic signed [IN_W-1:0] SAT_VAL  = IN_W'((2 ** OUT_W) - 1);

  if ((N_IN % POOL) != 0) begin : g_cfg_err
    $error("relu_pool_streamer: N_IN must be a multiple of POOL");
  end

  // Max over one pooling window, then ReLU, shift and saturate, all within IN_W bits.
  // After ReLU the value is non-negative, so >>> and >> agree and the shift cannot overflow.
  function automatic logic [OUT_W-1:0] pool_quant(input logic [POOL-1:0][IN_W-1:0] win);
    logic signed [IN_W-1:0] v_max;
    logic signed [IN_W-1:0] v_relu;
    logic signed [IN_W-1:0] v_shift;
    v_max = $signed(win[0]);
    for (int j = 1; j < POOL; j++) begin
      if ($signed(win[j]) > v_max) begin
        v_max = $signed(win[j]);
      end
    end
    if (v_max < ZERO_VAL) begin
      v_relu = ZERO_VAL;
    end else begin
      v_relu = v_max;
    end
    v_shift = v_relu >>> SHIFT;
    if (v_shift > SAT_VAL) begin
      pool_quant = {OUT_W{1'b1}};
    end else begin
      pool_quant = v_shift[OUT_W-1:0];
    end
  endfunction

  state_t                 r_state;
  logic signed [IN_W-1:0] r_buf [0:N_IN-1];
  logic                   r_out_valid;
  logic [OUT_W-1:0]       r_out_data;
  logic [K_W-1:0]         r_out_idx;
  logic                   r_out_last;
  logic                   r_busy;
  logic                   r_done;
  logic                   r_overrun;

  state_t                 w_state_nxt;
  logic                   w_valid_nxt;
  logic [OUT_W-1:0]       w_data_nxt;
  logic [K_W-1:0]         w_idx_nxt;
  logic                   w_last_nxt;
  logic                   w_busy_nxt;
  logic                   w_done_nxt;
  logic                   w_overrun_nxt;
  logic                   w_capture;
  logic [K_W-1:0]         w_idx_inc;
  logic [OUT_W-1:0]       w_pooled [N_OUT];

  // Every pooled result is available combinationally from the captured frame, so the
  // next output can be loaded on the same edge as the current handshake.
  for (genvar g = 0; g < N_OUT; g++) begin : g_pool
    logic [POOL-1:0][IN_W-1:0] w_win;
    for (genvar j = 0; j < POOL; j++) begin : g_win
      assign w_win[j] = r_buf[g*POOL + j];
    end
    assign w_pooled[g] = pool_quant(w_win);
  end

  assign w_idx_inc = r_out_idx + ONE_IDX;

  // Capture buffer: loaded only when an idle streamer accepts a frame.
  always_ff @(posedge clk) begin
    if (!rst) begin
      for (int i = 0; i < N_IN; i++) begin
        r_buf[i] <= ZERO_VAL;
      end
    end else if (w_capture) begin
      r_buf <= conv_result;
    end else begin
      r_buf <= r_buf;
    end
  end

  // State and output registers.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state     <= ST_IDLE;
      r_out_valid <= 1'b0;
      r_out_data  <= {OUT_W{1'b0}};
      r_out_idx   <= {K_W{1'b0}};
      r_out_last  <= 1'b0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_overrun   <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_out_valid <= w_valid_nxt;
      r_out_data  <= w_data_nxt;
      r_out_idx   <= w_idx_nxt;
      r_out_last  <= w_last_nxt;
      r_busy      <= w_busy_nxt;
      r_done      <= w_done_nxt;
      r_overrun   <= w_overrun_nxt;
    end
  end

  // Next-state and next-output logic.
  always_comb begin
    w_state_nxt   = r_state;
    w_valid_nxt   = r_out_valid;
    w_data_nxt    = r_out_data;
    w_idx_nxt     = r_out_idx;
    w_last_nxt    = r_out_last;
    w_busy_nxt    = r_busy;
    w_done_nxt    = 1'b0;
    w_overrun_nxt = 1'b0;
    w_capture     = 1'b0;
    case (r_state)
      ST_IDLE: begin
        // IDLE is also the state during the done pulse, so a frame arriving then is accepted.
        if (in_valid) begin
          w_capture   = 1'b1;
          w_idx_nxt   = {K_W{1'b0}};
          w_busy_nxt  = 1'b1;
          w_state_nxt = ST_LOAD;
        end else begin
          w_busy_nxt  = 1'b0;
        end
      end
      ST_LOAD: begin
        w_overrun_nxt = in_valid;
        w_valid_nxt   = 1'b1;
        w_data_nxt    = w_pooled[r_out_idx];
        w_last_nxt    = (r_out_idx == LAST_IDX);
        w_state_nxt   = ST_STREAM;
      end
      ST_STREAM: begin
        // out_valid is always high here, so out_ready alone marks a handshake.
        w_overrun_nxt = in_valid;
        if (out_ready) begin
          if (r_out_last) begin
            w_state_nxt = ST_IDLE;
            w_valid_nxt = 1'b0;
            w_last_nxt  = 1'b0;
            w_busy_nxt  = 1'b0;
            w_done_nxt  = 1'b1;
          end else begin
            w_idx_nxt   = w_idx_inc;
            w_data_nxt  = w_pooled[w_idx_inc];
            w_last_nxt  = (w_idx_inc == LAST_IDX);
          end
        end else begin
          w_state_nxt = ST_STREAM;
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
        w_valid_nxt = 1'b0;
        w_last_nxt  = 1'b0;
        w_busy_nxt  = 1'b0;
      end
    endcase
  end

  assign out_valid = r_out_valid;
  assign out_data  = r_out_data;
  assign out_idx   = r_out_idx;
  assign out_last  = r_out_last;
  assign busy      = r_busy;
  assign done      = r_done;
  assign overrun   = r_overrun;

endmodule

// File: tb/tb_relu_pool_streamer.sv
// Scoreboard bench for relu_pool_streamer: the stimulus side pushes reference-model results
// for every accepted frame; a negedge monitor pops and compares on each handshake and also
// checks hold-under-stall and the done pulse timing.
module tb_relu_pool_streamer;
  localparam int N_IN  = 30;
  localparam int IN_W  = 18;
  localparam int POOL  = 2;
  localparam int SHIFT = 2;
  localparam int OUT_W = 8;
  localparam int N_OUT = N_IN / POOL;
  localparam int K_W   = 4;
  localparam int SAT   = (1 << OUT_W) - 1;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic                   rst;
  logic                   in_valid;
  logic signed [IN_W-1:0] conv_result [0:N_IN-1];
  logic                   out_valid;
  logic                   out_ready;
  logic [OUT_W-1:0]       out_data;
  logic [K_W-1:0]         out_idx;
  logic                   out_last;
  logic                   busy;
  logic                   done;
  logic                   overrun;

  typedef struct {
    int data;
    int idx;
    bit last;
  } exp_t;

  exp_t exp_q[$];
  int   frame [N_IN];
  int   checks = 0;
  int   errors = 0;
  int   ready_mode = 0;
  int   rdy_phase = 0;

  relu_pool_streamer #(
    .N_IN(N_IN), .IN_W(IN_W), .POOL(POOL), .SHIFT(SHIFT), .OUT_W(OUT_W)
  ) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .conv_result(conv_result),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_idx(out_idx), .out_last(out_last), .busy(busy), .done(done),
    .overrun(overrun)
  );

  // Reference: integer max of the window, clamp below at 0, divide by 2**SHIFT, clamp at SAT.
  function automatic int ref_out(int k);
    int m;
    m = frame[k*POOL];
    for (int j = 1; j < POOL; j++) begin
      if (frame[k*POOL + j] > m) m = frame[k*POOL + j];
    end
    if (m < 0) m = 0;
    m = m / (1 << SHIFT);
    if (m > SAT) m = SAT;
    return m;
  endfunction

  task automatic chk(string name, int act, int exp_v);
    checks++;
    if (act != exp_v) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp_v);
    end
  endtask

  task automatic rand_frame();
    for (int i = 0; i < N_IN; i++) begin
      case ($urandom_range(0, 3))
        0:       frame[i] = int'($urandom_range(0, 600)) - 300;
        1:       frame[i] = int'($urandom_range(0, 262143)) - 131072;
        2:       frame[i] = int'($urandom_range(900, 1100));
        default: frame[i] = -int'($urandom_range(1, 131072));
      endcase
    end
  endtask

  task automatic drive_conv();
    for (int i = 0; i < N_IN; i++) conv_result[i] = IN_W'(frame[i]);
  endtask

  // Pulses in_valid for one cycle; returns #1 after the edge that sampled it.
  task automatic send_frame(bit expect_it);
    drive_conv();
    in_valid = 1'b1;
    if (expect_it) begin
      for (int k = 0; k < N_OUT; k++) begin
        exp_q.push_back('{data: ref_out(k), idx: k, last: (k == N_OUT - 1)});
      end
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic wait_done(output int cnt);
    cnt = 0;
    while (cnt < 400) begin
      @(posedge clk); #1;
      cnt++;
      if (done) break;
    end
    chk("done_seen", int'(done), 1);
  endtask

  task automatic wait_idx(int k);
    int n;
    n = 0;
    while (!(out_valid && int'(out_idx) == k) && n < 400) begin
      @(posedge clk); #1;
      n++;
    end
    chk("reach_idx", int'(out_valid && int'(out_idx) == k), 1);
  endtask

  task automatic check_reset(string name);
    chk(name, int'({out_valid, out_data, out_idx, out_last, busy, done, overrun}), 0);
  endtask

  // out_ready driver: 0 = always ready, 1 = pattern 1,0,0 repeating, 2 = random.
  initial begin
    out_ready = 1'b0;
    forever begin
      @(posedge clk); #1;
      case (ready_mode)
        0: out_ready = 1'b1;
        1: begin
          out_ready = (rdy_phase == 0);
          rdy_phase = (rdy_phase + 1) % 3;
        end
        default: out_ready = 1'($urandom_range(0, 1));
      endcase
    end
  end

  // Monitor: handshakes against the scoreboard, hold-under-stall, done one cycle after last.
  initial begin
    bit   prev_stall;
    bit   prev_last_hs;
    int   pd;
    int   pi;
    bit   pl;
    exp_t e;
    prev_stall = 1'b0;
    prev_last_hs = 1'b0;
    pd = 0;
    pi = 0;
    pl = 1'b0;
    forever begin
      @(negedge clk);
      if (rst === 1'b1) begin
        chk("done_pulse", int'(done), int'(prev_last_hs));
        if (prev_stall) begin
          chk("stall_valid", int'(out_valid), 1);
          chk("stall_data", int'(out_data), pd);
          chk("stall_idx", int'(out_idx), pi);
          chk("stall_last", int'(out_last), int'(pl));
        end
        if (out_valid && out_ready) begin
          if (exp_q.size() == 0) begin
            chk("unexpected_output_idx", int'(out_idx), -1);
          end else begin
            e = exp_q.pop_front();
            chk("out_data", int'(out_data), e.data);
            chk("out_idx", int'(out_idx), e.idx);
            chk("out_last", int'(out_last), int'(e.last));
          end
        end
        prev_stall   = out_valid && !out_ready;
        prev_last_hs = out_valid && out_ready && out_last;
        pd = int'(out_data);
        pi = int'(out_idx);
        pl = out_last;
      end else begin
        prev_stall   = 1'b0;
        prev_last_hs = 1'b0;
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int cnt;
    rst = 1'b0;
    in_valid = 1'b0;
    for (int i = 0; i < N_IN; i++) frame[i] = 0;
    drive_conv();
    repeat (3) @(posedge clk);
    #1;
    check_reset("reset_state");
    rst = 1'b1;
    ready_mode = 0;
    repeat (2) @(posedge clk);
    #1;

    // Directed frame: boundary values for ReLU, shift and saturation.
    frame[0] = -5;     frame[1] = 40;
    frame[2] = -100;   frame[3] = -1;
    frame[4] = 131071; frame[5] = 0;
    frame[6] = 1023;   frame[7] = 1020;
    frame[8] = 1024;   frame[9] = 7;
    send_frame(1'b1);
    chk("latency_load_valid", int'(out_valid), 0);
    chk("busy_after_capture", int'(busy), 1);
    @(posedge clk); #1;
    chk("latency_first_valid", int'(out_valid), 1);
    wait_done(cnt);
    chk("frame_len", cnt, N_OUT);
    chk("busy_at_done", int'(busy), 0);

    // Back-to-back: new frame in the done cycle.
    rand_frame();
    send_frame(1'b1);
    chk("b2b_busy", int'(busy), 1);
    chk("b2b_load_valid", int'(out_valid), 0);
    @(posedge clk); #1;
    chk("b2b_first_valid", int'(out_valid), 1);
    wait_done(cnt);

    // Backpressure: fixed 1,0,0 pattern, then random ready.
    ready_mode = 1;
    for (int f = 0; f < 2; f++) begin
      @(posedge clk); #1;
      rand_frame();
      send_frame(1'b1);
      wait_done(cnt);
    end
    ready_mode = 2;
    for (int f = 0; f < 4; f++) begin
      @(posedge clk); #1;
      rand_frame();
      send_frame(1'b1);
      wait_done(cnt);
    end

    // Overrun: a second frame at idx 5 is dropped and the first one completes unchanged.
    ready_mode = 0;
    repeat (2) @(posedge clk);
    #1;
    rand_frame();
    send_frame(1'b1);
    wait_idx(5);
    rand_frame();
    drive_conv();
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    chk("overrun_pulse", int'(overrun), 1);
    chk("overrun_busy", int'(busy), 1);
    @(posedge clk); #1;
    chk("overrun_clear", int'(overrun), 0);
    wait_done(cnt);
    repeat (4) @(posedge clk);
    #1;
    chk("no_second_frame", int'(out_valid), 0);

    // Reset while idx 7 is presented: frame abandoned, no done, clean restart at idx 0.
    rand_frame();
    send_frame(1'b1);
    wait_idx(7);
    rst = 1'b0;
    exp_q.delete();
    @(posedge clk); #1;
    check_reset("mid_stream_reset");
    rst = 1'b1;
    @(posedge clk); #1;
    chk("no_done_after_reset", int'(done), 0);
    rand_frame();
    send_frame(1'b1);
    @(posedge clk); #1;
    chk("restart_valid", int'(out_valid), 1);
    chk("restart_idx", int'(out_idx), 0);
    wait_done(cnt);

    repeat (3) @(posedge clk);
    #1;
    chk("queue_empty", exp_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
